// File: rtl/niosii_processor_nios_proc_cpu_debug_host_driver.sv
// Host-side virtual-JTAG initiator for the CPU debug slave.
// Plays one command as UIR -> CDR -> SDR(DR_WIDTH bits) -> UDR -> RTI on a
// divided, registered tck and returns the tdo bits captured during SDR.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high, rti high, tck low
// UIR   | one tck period with vs_uir high, ir_in already presented
// CDR   | one tck period with vs_cdr high, shift register loaded
// SDR   | DR_WIDTH tck periods, tdi = sr[0], tdo sampled on tck rise
// UDR   | one tck period with vs_udr high
// RTI   | one tck period with rti high
// DONE  | one clk cycle, rsp_valid high, then back to IDLE
module niosii_processor_nios_proc_cpu_debug_host_driver #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [IR_WIDTH-1:0] cmd_ir_i,
    input  logic [DR_WIDTH-1:0] cmd_data_i,
    output logic                rsp_valid_o,
    output logic [DR_WIDTH-1:0] rsp_data_o,
    output logic                busy_o,
    output logic                tck_o,
    output logic                tdi_o,
    input  logic                tdo_i,
    output logic [IR_WIDTH-1:0] ir_in_o,
    output logic                vs_uir_o,
    output logic                vs_cdr_o,
    output logic                vs_sdr_o,
    output logic                vs_udr_o,
    output logic                rti_o
);

    // A divide-by-one tck still needs a (constant zero) counter bit.
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = $clog2(DR_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [BIT_W-1:0]    bit_q;
    logic [DR_WIDTH-1:0] data_q;
    logic [DR_WIDTH-1:0] sr_q;
    logic [DR_WIDTH-1:0] rsp_data_q;
    logic [IR_WIDTH-1:0] ir_in_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic                busy_q;
    logic                tck_q;
    logic                tdi_q;
    logic                vs_uir_q;
    logic                vs_cdr_q;
    logic                vs_sdr_q;
    logic                vs_udr_q;
    logic                rti_q;

    // Sequencer: tck generation, strobe sequencing and SDR shifting in one FSM.
    // Strobes and tdi only move at the falling tck edge (period start); tdo is
    // sampled on the clk edge that raises tck.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            sr_q        <= '0;
            rsp_data_q  <= '0;
            ir_in_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            vs_uir_q    <= 1'b0;
            vs_cdr_q    <= 1'b0;
            vs_sdr_q    <= 1'b0;
            vs_udr_q    <= 1'b0;
            rti_q       <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid_i && cmd_ready_q) begin
                        state_q     <= S_UIR;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        ir_in_q     <= cmd_ir_i;
                        data_q      <= cmd_data_i;
                        div_q       <= '0;
                        tck_q       <= 1'b0;
                        rti_q       <= 1'b0;
                        vs_uir_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        if (!tck_q) begin
                            tck_q <= 1'b1;
                            if (state_q == S_SDR) begin
                                sr_q <= {tdo_i, sr_q[DR_WIDTH-1:1]};
                            end
                        end else begin
                            tck_q <= 1'b0;
                            case (state_q)
                                S_UIR: begin
                                    state_q  <= S_CDR;
                                    vs_uir_q <= 1'b0;
                                    vs_cdr_q <= 1'b1;
                                    sr_q     <= data_q;
                                end
                                S_CDR: begin
                                    state_q  <= S_SDR;
                                    vs_cdr_q <= 1'b0;
                                    vs_sdr_q <= 1'b1;
                                    tdi_q    <= sr_q[0];
                                    bit_q    <= '0;
                                end
                                S_SDR: begin
                                    if (bit_q == BIT_LAST) begin
                                        state_q  <= S_UDR;
                                        vs_sdr_q <= 1'b0;
                                        vs_udr_q <= 1'b1;
                                        tdi_q    <= 1'b0;
                                    end else begin
                                        bit_q <= bit_q + BIT_W'(1);
                                        tdi_q <= sr_q[0];
                                    end
                                end
                                S_UDR: begin
                                    state_q  <= S_RTI;
                                    vs_udr_q <= 1'b0;
                                    rti_q    <= 1'b1;
                                end
                                S_RTI: begin
                                    state_q     <= S_DONE;
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= sr_q;
                                end
                                default: begin
                                    state_q <= S_IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = busy_q;
    assign tck_o       = tck_q;
    assign tdi_o       = tdi_q;
    assign ir_in_o     = ir_in_q;
    assign vs_uir_o    = vs_uir_q;
    assign vs_cdr_o    = vs_cdr_q;
    assign vs_sdr_o    = vs_sdr_q;
    assign vs_udr_o    = vs_udr_q;
    assign rti_o       = rti_q;

endmodule

// File: tb/tb_niosii_processor_nios_proc_cpu_debug_host_driver.sv
// Bench for the debug host driver: table of commands with a response
// scoreboard, plus hand-written idle, back-to-back and mid-SDR reset cases.
module tb_niosii_processor_nios_proc_cpu_debug_host_driver;

    localparam int DR  = 38;
    localparam int IRW = 2;
    localparam int P_A = 4;                 // clk cycles per tck period, DUT A
    localparam int LAT_A = P_A * (DR + 4) + 1;
    localparam int LAT_B = 2 * (DR + 4) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // DUT A: default TCK_DIV=2
    logic           cmd_valid_a = 1'b0, cmd_ready_a;
    logic [IRW-1:0] cmd_ir_a = '0, ir_in_a;
    logic [DR-1:0]  cmd_data_a = '0, rsp_data_a;
    logic           rsp_valid_a, busy_a, tck_a, tdi_a, tdo_a;
    logic           vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a, rti_a;
    logic [1:0]     tdo_mode = 2'd0;        // 0: tie 0, 1: tie 1, 2: 1-tck loopback
    logic           loop_q = 1'b0;

    // DUT B: TCK_DIV=1, tdo tied 0
    logic           cmd_valid_b = 1'b0, cmd_ready_b;
    logic [IRW-1:0] cmd_ir_b = 2'b10, ir_in_b;
    logic [DR-1:0]  cmd_data_b = '0, rsp_data_b;
    logic           rsp_valid_b, busy_b, tck_b, tdi_b;
    logic           tdo_b = 1'b0;
    logic           vs_uir_b, vs_cdr_b, vs_sdr_b, vs_udr_b, rti_b;

    assign tdo_a = (tdo_mode == 2'd2) ? loop_q : tdo_mode[0];

    niosii_processor_nios_proc_cpu_debug_host_driver dut_a (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid_a), .cmd_ready_o(cmd_ready_a),
        .cmd_ir_i(cmd_ir_a), .cmd_data_i(cmd_data_a), .rsp_valid_o(rsp_valid_a),
        .rsp_data_o(rsp_data_a), .busy_o(busy_a), .tck_o(tck_a), .tdi_o(tdi_a),
        .tdo_i(tdo_a), .ir_in_o(ir_in_a), .vs_uir_o(vs_uir_a), .vs_cdr_o(vs_cdr_a),
        .vs_sdr_o(vs_sdr_a), .vs_udr_o(vs_udr_a), .rti_o(rti_a));

    niosii_processor_nios_proc_cpu_debug_host_driver #(.TCK_DIV(1)) dut_b (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b),
        .cmd_ir_i(cmd_ir_b), .cmd_data_i(cmd_data_b), .rsp_valid_o(rsp_valid_b),
        .rsp_data_o(rsp_data_b), .busy_o(busy_b), .tck_o(tck_b), .tdi_o(tdi_b),
        .tdo_i(tdo_b), .ir_in_o(ir_in_b), .vs_uir_o(vs_uir_b), .vs_cdr_o(vs_cdr_b),
        .vs_sdr_o(vs_sdr_b), .vs_udr_o(vs_udr_b), .rti_o(rti_b));

    int tests = 0;
    int failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DR-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e_pop;

    // slave model on A's tck: loopback register and record of tdi on SDR rising edges
    int            sdr_total = 0;
    logic [DR-1:0] tdi_shift = '0;
    always @(posedge tck_a) begin
        loop_q <= tdi_a;
        if (vs_sdr_a) begin
            sdr_total++;
            tdi_shift = {tdi_a, tdi_shift[DR-1:1]};
        end
    end

    // response scoreboard and per-cycle protocol checks on A
    int   uir_start = 0, cdr_start = 0, sdr_start = 0, udr_start = 0, sdr_cycles = 0;
    logic p_uir = 1'b0, p_cdr = 1'b0, p_sdr = 1'b0, p_udr = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (rsp_valid_a) begin
                check("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e_pop = sb.pop_front();
                    check("rsp_data", 64'(rsp_data_a), 64'(e_pop.data));
                    check("rsp_cycle", 64'(cyc), 64'(e_pop.cyc));
                end
            end
            if (busy_a)
                check("strobe_onehot",
                      64'($countones({vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a, rti_a})), 64'd1);
            if (!vs_sdr_a) check("tdi_outside_sdr", 64'(tdi_a), 64'd0);
            if (vs_uir_a && !p_uir) uir_start = cyc;
            if (vs_cdr_a && !p_cdr) cdr_start = cyc;
            if (vs_sdr_a && !p_sdr) sdr_start = cyc;
            if (vs_udr_a && !p_udr) udr_start = cyc;
            if (vs_sdr_a) sdr_cycles++;
            p_uir = vs_uir_a;
            p_cdr = vs_cdr_a;
            p_sdr = vs_sdr_a;
            p_udr = vs_udr_a;
        end
    end

    // one command on A: drive, scoreboard push on acceptance, wait for drain, then check the frame
    task automatic run_cmd(input logic [IRW-1:0] ir, input logic [DR-1:0] data,
                           input logic [1:0] mode, input logic [DR-1:0] exp);
        int  acc = 0;
        int  base_sdr;
        int  base_cyc;
        bit  got = 0;
        @(negedge clk);
        cmd_ir_a    = ir;
        cmd_data_a  = data;
        tdo_mode    = mode;
        cmd_valid_a = 1'b1;
        for (int n = 0; n < 50 && !got; n++) begin
            if (cmd_ready_a) begin
                got = 1;
                acc = cyc;
                sb.push_back('{data: exp, cyc: cyc + LAT_A});
            end else begin
                @(negedge clk);
            end
        end
        check("accept", 64'(got), 64'd1);
        base_sdr = sdr_total;
        base_cyc = sdr_cycles;
        @(negedge clk);
        cmd_valid_a = 1'b0;
        cmd_data_a  = ~data;
        cmd_ir_a    = ~ir;
        for (int n = 0; n < 400 && sb.size() > 0; n++) @(negedge clk);
        check("rsp_timeout", 64'(sb.size()), 64'd0);
        check("sdr_rising_edges", 64'(sdr_total - base_sdr), 64'(DR));
        check("tdi_payload", 64'(tdi_shift), 64'(data));
        check("ir_in", 64'(ir_in_a), 64'(ir));
        check("uir_start", 64'(uir_start), 64'(acc + 1));
        check("cdr_start", 64'(cdr_start), 64'(acc + 1 + P_A));
        check("sdr_start", 64'(sdr_start), 64'(acc + 1 + 2 * P_A));
        check("udr_start", 64'(udr_start), 64'(acc + 1 + (2 + DR) * P_A));
        check("sdr_cycles", 64'(sdr_cycles - base_cyc), 64'(DR * P_A));
    endtask

    typedef struct {
        logic [IRW-1:0] ir;
        logic [DR-1:0]  data;
        logic [1:0]     mode;
        logic [DR-1:0]  exp;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic [DR-1:0] d;
        int acc_b[$];
        int rsp_b[$];
        bool_dummy: begin end
        d = 38'h2A_5A5A_5A5A; vecs[0] = '{2'b01, d, 2'd2, d << 1};
        d = 38'h00_0000_0000; vecs[1] = '{2'b10, d, 2'd1, 38'h3F_FFFF_FFFF};
        d = 38'h3F_FFFF_FFFF; vecs[2] = '{2'b11, d, 2'd0, 38'h00_0000_0000};
        d = 38'h01_2345_6789; vecs[3] = '{2'b00, d, 2'd2, d << 1};
        d = 38'h20_0000_0001; vecs[4] = '{2'b01, d, 2'd2, d << 1};
        d = 38'h15_5555_5555; vecs[5] = '{2'b10, d, 2'd1, 38'h3F_FFFF_FFFF};

        // reset values while reset is held
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({tck_a, tdi_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a,
                                 rti_a, rsp_valid_a, busy_a, cmd_ready_a}), 64'b0000001000);
        check("reset_rsp_data", 64'(rsp_data_a), 64'd0);
        check("reset_ir_in", 64'(ir_in_a), 64'd0);
        reset = 1'b0;

        // idle steady for 500 cycles after release
        @(negedge clk);
        for (int i = 0; i < 500; i++) begin
            check("idle_steady", 64'({tck_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a,
                                      rti_a, cmd_ready_a, busy_a}), 64'b00000110);
            @(negedge clk);
        end

        // table of commands
        foreach (vecs[i]) run_cmd(vecs[i].ir, vecs[i].data, vecs[i].mode, vecs[i].exp);

        // ir_in holds the last command's IR while idle; cmd_ir_a was already changed
        repeat (5) @(negedge clk);
        check("ir_in_hold", 64'(ir_in_a), 64'(vecs[5].ir));

        // reset at SDR bit 17: outputs clear without a clock, no response afterwards
        begin
            int base;
            bit got = 0;
            @(negedge clk);
            cmd_ir_a = 2'b11; cmd_data_a = 38'h0F_0F0F_0F0F; tdo_mode = 2'd1; cmd_valid_a = 1'b1;
            for (int n = 0; n < 50 && !got; n++) begin
                if (cmd_ready_a) begin
                    got = 1;
                    sb.push_back('{data: 38'h3F_FFFF_FFFF, cyc: cyc + LAT_A});
                end else begin
                    @(negedge clk);
                end
            end
            check("abort_accept", 64'(got), 64'd1);
            base = sdr_total;
            @(negedge clk);
            cmd_valid_a = 1'b0;
            for (int n = 0; n < 400 && (sdr_total - base) < 17; n++) @(negedge clk);
            check("abort_reach_bit17", 64'(sdr_total - base), 64'd17);
            #2 reset = 1'b1;
            #1;
            check("abort_ctrl", 64'({tck_a, tdi_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_udr_a,
                                     rti_a, rsp_valid_a, busy_a, cmd_ready_a}), 64'b0000001000);
            check("abort_rsp_data", 64'(rsp_data_a), 64'd0);
            check("abort_ir_in", 64'(ir_in_a), 64'd0);
            repeat (3) @(negedge clk);
            reset = 1'b0;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                if (rsp_valid_a) check("abort_no_rsp", 64'(rsp_valid_a), 64'd0);
            end
            check("abort_idle", 64'({busy_a, cmd_ready_a, rti_a}), 64'b011);
        end
        run_cmd(2'b01, 38'h33_CCCC_3333, 2'd2, 38'h33_CCCC_3333 << 1);

        // back-to-back on the TCK_DIV=1 instance with cmd_valid held high
        @(negedge clk);
        cmd_valid_b = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (cmd_valid_b && cmd_ready_b) acc_b.push_back(cyc);
            if (rsp_valid_b) begin
                rsp_b.push_back(cyc);
                check("b_rsp_data", 64'(rsp_data_b), 64'd0);
            end
            if (acc_b.size() == 1 && cyc == acc_b[0] + 40) begin
                check("b_mid_sdr_state", 64'({cmd_ready_b, busy_b, vs_sdr_b}), 64'b011);
                cmd_data_b = 38'h3F_0000_FFFF;
                cmd_ir_b   = 2'b01;
            end
            @(negedge clk);
        end
        cmd_valid_b = 1'b0;
        check("b_accept_count", 64'(acc_b.size() >= 3), 64'd1);
        check("b_rsp_count", 64'(rsp_b.size() >= 2), 64'd1);
        for (int i = 1; i < acc_b.size(); i++)
            check("b_accept_spacing", 64'(acc_b[i] - acc_b[i-1]), 64'(LAT_B + 1));
        for (int i = 0; i < rsp_b.size() && i < acc_b.size(); i++)
            check("b_rsp_latency", 64'(rsp_b[i] - acc_b[i]), 64'(LAT_B));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // global time limit
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
